// File: rtl/bti_arb2_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_trans_if_t
//  Description : Single-outstanding bus-transaction interface. A request
//                channel (req_vld/req_rdy/req_pkt) travels from master to
//                slave. A response channel (rsp_vld/rsp_rdy/rsp_pkt) travels
//                from slave back to master. Both channels use a valid/ready
//                handshake: a beat transfers on a cycle where vld & rdy.
//  Parameters  : AW - width of req_pkt.addr
//                DW - width of req_pkt.wdata and rsp_pkt.data
//  Modports    : master - drives the request channel, accepts responses
//                slave  - accepts requests, drives the response channel
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_trans_if_t #(
    parameter int AW = 32,
    parameter int DW = 32
);

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic            we;
        logic [DW-1:0]   wdata;
        logic [DW/8-1:0] be;
    } req_pkt_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } rsp_pkt_t;

    logic     req_vld;
    logic     req_rdy;
    req_pkt_t req_pkt;

    logic     rsp_vld;
    logic     rsp_rdy;
    rsp_pkt_t rsp_pkt;

    modport master (
        output req_vld,
        output req_pkt,
        input  req_rdy,
        input  rsp_vld,
        input  rsp_pkt,
        output rsp_rdy
    );

    modport slave (
        input  req_vld,
        input  req_pkt,
        output req_rdy,
        output rsp_vld,
        output rsp_pkt,
        input  rsp_rdy
    );

endinterface
`default_nettype wire

// File: rtl/bti_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : bti_arb2
//  Description : 2:1 round-robin arbiter sharing one bus-transaction slave
//                between two masters (port 0: instruction fetch, port 1:
//                data/load). Exactly one transaction is outstanding at a
//                time. Requests pass combinationally to the slave; responses
//                are steered back to the master owning the in-flight
//                transaction. No pipeline stage is added on either path.
//  Ports       : clk     - clock
//                rst_n   - synchronous active-low reset
//                bti_m0  - requester 0 (arbiter is the slave side)
//                bti_m1  - requester 1 (arbiter is the slave side)
//                bti_s   - shared downstream slave (arbiter is the master)
//  Parameters  : AW - request address width (passed through unchanged)
//                DW - data width (passed through unchanged)
//  Revision    : 1.0 - initial release
// ============================================================================
module bti_arb2 #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  wire           clk,
    input  wire           rst_n,
    bus_trans_if_t.slave  bti_m0,
    bus_trans_if_t.slave  bti_m1,
    bus_trans_if_t.master bti_s
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t r_state;
    logic   r_owner;      // master that owns the in-flight transaction
    logic   r_last_gnt;   // most recently accepted master
    logic   r_lock;       // a request was offered but not yet accepted
    logic   r_lock_id;    // master held by the lock

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic w_busy;
    logic w_rsp_hs;
    logic w_issue_ok;
    logic w_any_req;
    logic w_gnt;
    logic w_s_req_vld;
    logic w_s_rsp_rdy;
    logic w_accept;
    logic w_stall;

    // Request payload mux, field by field so every field keeps its width.
    logic [AW-1:0]   w_req_addr;
    logic            w_req_we;
    logic [DW-1:0]   w_req_wdata;
    logic [DW/8-1:0] w_req_be;

    // Response payload fanned out to both masters.
    logic [DW-1:0]   w_rsp_data;
    logic            w_rsp_err;

    assign w_busy = (r_state == ST_BUSY);

    // The slave only ever has a response for us while BUSY, so the upstream
    // ready of the owner is forwarded only in that state. A stray rsp_vld in
    // IDLE therefore never handshakes.
    assign w_s_rsp_rdy = w_busy & (r_owner ? bti_m1.rsp_rdy : bti_m0.rsp_rdy);
    assign w_rsp_hs    = w_busy & bti_s.rsp_vld & w_s_rsp_rdy;

    // A new request may go out when idle, or in the very cycle the current
    // response completes, giving back-to-back transactions without a bubble.
    // Note the resulting path rsp_rdy -> issue_ok -> req_rdy.
    assign w_issue_ok = ~w_busy | w_rsp_hs;

    // Grant selection. While locked the grant is frozen so the offered
    // request (and its payload) stays stable until the slave takes it.
    // With a single requester it wins; on a tie the master not granted
    // last time wins. With no requester the value is irrelevant because
    // the downstream valid is low.
    always_comb begin
        w_gnt = 1'b0;
        if (r_lock) begin
            w_gnt = r_lock_id;
        end else if (bti_m0.req_vld & bti_m1.req_vld) begin
            w_gnt = ~r_last_gnt;
        end else if (bti_m1.req_vld) begin
            w_gnt = 1'b1;
        end else begin
            w_gnt = 1'b0;
        end
    end

    assign w_any_req   = r_lock | bti_m0.req_vld | bti_m1.req_vld;
    assign w_s_req_vld = w_issue_ok & w_any_req;
    assign w_accept    = w_s_req_vld & bti_s.req_rdy;
    assign w_stall     = w_s_req_vld & ~bti_s.req_rdy;

    // ------------------------------------------------------------------
    // Downstream request
    // ------------------------------------------------------------------
    assign w_req_addr  = w_gnt ? bti_m1.req_pkt.addr  : bti_m0.req_pkt.addr;
    assign w_req_we    = w_gnt ? bti_m1.req_pkt.we    : bti_m0.req_pkt.we;
    assign w_req_wdata = w_gnt ? bti_m1.req_pkt.wdata : bti_m0.req_pkt.wdata;
    assign w_req_be    = w_gnt ? bti_m1.req_pkt.be    : bti_m0.req_pkt.be;

    assign bti_s.req_vld       = w_s_req_vld;
    assign bti_s.req_pkt.addr  = w_req_addr;
    assign bti_s.req_pkt.we    = w_req_we;
    assign bti_s.req_pkt.wdata = w_req_wdata;
    assign bti_s.req_pkt.be    = w_req_be;

    // Only the granted master can see ready; the other always sees 0.
    assign bti_m0.req_rdy = w_issue_ok & ~w_gnt & bti_s.req_rdy;
    assign bti_m1.req_rdy = w_issue_ok &  w_gnt & bti_s.req_rdy;

    // ------------------------------------------------------------------
    // Response steering
    // ------------------------------------------------------------------
    assign w_rsp_data = bti_s.rsp_pkt.data;
    assign w_rsp_err  = bti_s.rsp_pkt.err;

    assign bti_s.rsp_rdy = w_s_rsp_rdy;

    assign bti_m0.rsp_vld      = w_busy & ~r_owner & bti_s.rsp_vld;
    assign bti_m0.rsp_pkt.data = w_rsp_data;
    assign bti_m0.rsp_pkt.err  = w_rsp_err;

    assign bti_m1.rsp_vld      = w_busy &  r_owner & bti_s.rsp_vld;
    assign bti_m1.rsp_pkt.data = w_rsp_data;
    assign bti_m1.rsp_pkt.err  = w_rsp_err;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    // last_gnt resets to 1 so that m0 wins the first tie after reset.
    // A reset during a transaction simply drops the pending response; the
    // masters and the slave are reset in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_owner    <= 1'b0;
            r_last_gnt <= 1'b1;
            r_lock     <= 1'b0;
            r_lock_id  <= 1'b0;
        end else begin
            if (w_accept) begin
                // Covers both IDLE->BUSY and the back-to-back BUSY->BUSY
                // case where a response completes in the same cycle.
                r_state    <= ST_BUSY;
                r_owner    <= w_gnt;
                r_last_gnt <= w_gnt;
                r_lock     <= 1'b0;
            end else begin
                if (w_stall) begin
                    r_lock    <= 1'b1;
                    r_lock_id <= w_gnt;
                end
                if (w_rsp_hs) begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bti_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bti_arb2
//  Description : Self-checking bench for bti_arb2. A transaction-level
//                reference (outstanding-transaction queue, pending offer,
//                last winner) predicts every observable output each cycle.
//                Directed scenarios are followed by a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bti_arb2;

    logic clk;
    logic rst_n;

    bus_trans_if_t #(.AW(32), .DW(32)) m0_if ();
    bus_trans_if_t #(.AW(32), .DW(32)) m1_if ();
    bus_trans_if_t #(.AW(32), .DW(32)) s_if ();

    bti_arb2 #(.AW(32), .DW(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bti_m0 (m0_if),
        .bti_m1 (m1_if),
        .bti_s  (s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus driven by the masters and the slave.
    logic        m_vld  [2];
    logic [31:0] m_addr [2];
    logic        m_rrdy [2];
    logic        s_rdy;
    logic        s_stray;
    int          s_dly_cfg;

    // Slave behaviour: one pending response, released after a delay.
    bit          s_busy;
    int          s_dly;
    logic [31:0] s_data;
    int          seq;
    logic        drv_rvld;

    // Reference: transactions in flight (owner + the data it must receive),
    // the master whose offer is pending (-1 if none), and the last winner.
    typedef struct {
        int          id;
        logic [31:0] data;
    } txn_t;
    txn_t outst_q[$];
    int   offered;
    int   last_id;

    // Per-cycle predictions used by the update step.
    bit e_svld;
    bit e_acc;
    bit e_rsphs;
    int e_g;

    // Snapshots taken at the sampling edge for directed checks.
    logic        ob_svld;
    logic [31:0] ob_saddr;
    logic        ob_rdy   [2];
    logic        ob_rvld  [2];
    logic        ob_srrdy;
    logic [31:0] ob_rdata [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        m0_if.req_vld       = m_vld[0];
        m0_if.req_pkt.addr  = m_addr[0];
        m0_if.req_pkt.we    = 1'b0;
        m0_if.req_pkt.wdata = ~m_addr[0];
        m0_if.req_pkt.be    = 4'hF;
        m0_if.rsp_rdy       = m_rrdy[0];
        m1_if.req_vld       = m_vld[1];
        m1_if.req_pkt.addr  = m_addr[1];
        m1_if.req_pkt.we    = 1'b1;
        m1_if.req_pkt.wdata = ~m_addr[1];
        m1_if.req_pkt.be    = 4'h3;
        m1_if.rsp_rdy       = m_rrdy[1];
        drv_rvld            = (s_busy && s_dly == 0) || (!s_busy && s_stray);
        s_if.req_rdy        = s_rdy;
        s_if.rsp_vld        = drv_rvld;
        s_if.rsp_pkt.data   = s_busy ? s_data : 32'hDEAD_BEEF;
        s_if.rsp_pkt.err    = 1'b0;
    endtask

    task automatic reset_model();
        outst_q.delete();
        offered = -1;
        last_id = 1;
        s_busy  = 0;
        s_dly   = 0;
        seq     = 0;
        e_svld  = 0;
        e_acc   = 0;
        e_rsphs = 0;
        e_g     = 0;
    endtask

    task automatic model_check();
        bit busy;
        int own;
        bit win;
        bit any;
        int g;
        busy = (outst_q.size() != 0);
        own  = busy ? outst_q[0].id : 0;
        e_rsphs = busy && drv_rvld && m_rrdy[own];
        win  = !busy || e_rsphs;
        any  = (offered >= 0) || m_vld[0] || m_vld[1];
        if (offered >= 0)             g = offered;
        else if (m_vld[0] && m_vld[1]) g = 1 - last_id;
        else                          g = m_vld[1] ? 1 : 0;
        e_g    = g;
        e_svld = win && any;
        e_acc  = e_svld && s_rdy;

        ob_svld     = s_if.req_vld;
        ob_saddr    = s_if.req_pkt.addr;
        ob_rdy[0]   = m0_if.req_rdy;
        ob_rdy[1]   = m1_if.req_rdy;
        ob_rvld[0]  = m0_if.rsp_vld;
        ob_rvld[1]  = m1_if.rsp_vld;
        ob_srrdy    = s_if.rsp_rdy;
        ob_rdata[0] = m0_if.rsp_pkt.data;
        ob_rdata[1] = m1_if.rsp_pkt.data;

        chk("s_req_vld", 32'(ob_svld), 32'(e_svld));
        if (e_svld) begin
            chk("s_req_addr", ob_saddr, m_addr[g]);
            chk("s_req_wdata", s_if.req_pkt.wdata, ~m_addr[g]);
            chk("s_req_we", 32'(s_if.req_pkt.we), 32'(g == 1));
        end
        if (any) begin
            chk("m0_req_rdy", 32'(ob_rdy[0]), 32'(win && g == 0 && s_rdy));
            chk("m1_req_rdy", 32'(ob_rdy[1]), 32'(win && g == 1 && s_rdy));
        end
        chk("m0_rsp_vld", 32'(ob_rvld[0]), 32'(busy && own == 0 && drv_rvld));
        chk("m1_rsp_vld", 32'(ob_rvld[1]), 32'(busy && own == 1 && drv_rvld));
        chk("s_rsp_rdy", 32'(ob_srrdy), 32'(busy && m_rrdy[own]));
        if (e_rsphs) begin
            chk(own == 0 ? "m0_rsp_data" : "m1_rsp_data", ob_rdata[own], outst_q[0].data);
        end
    endtask

    task automatic model_update();
        if (e_rsphs) begin
            void'(outst_q.pop_front());
            s_busy = 0;
        end else if (s_busy && s_dly > 0) begin
            s_dly--;
        end
        if (e_acc) begin
            seq++;
            s_busy  = 1;
            s_dly   = s_dly_cfg;
            s_data  = 32'hA5A5_0000 + 32'(seq);
            outst_q.push_back('{id: e_g, data: s_data});
            last_id = e_g;
            offered = -1;
        end else if (e_svld) begin
            offered = e_g;
        end
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        if (rst_n) model_check();
        @(posedge clk);
        #1;
        if (!rst_n) reset_model();
        else        model_update();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        m_vld[0] = 1'b0;
        m_vld[1] = 1'b0;
        s_stray  = 1'b0;
        step();
        step();
        rst_n    = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        m_vld[0]  = 1'b0;  m_vld[1]  = 1'b0;
        m_addr[0] = '0;    m_addr[1] = '0;
        m_rrdy[0] = 1'b1;  m_rrdy[1] = 1'b1;
        s_rdy     = 1'b1;
        s_stray   = 1'b0;
        s_dly_cfg = 0;
        s_data    = '0;
        reset_model();

        // ---- Reset state, then m0 single read ----
        do_reset();
        step();
        chk("rst_s_req_vld", 32'(ob_svld), 32'd0);
        chk("rst_m0_rsp_vld", 32'(ob_rvld[0]), 32'd0);
        m_vld[0] = 1'b1; m_addr[0] = 32'h0000_0010;
        step();
        chk("t1_m0_req_rdy", 32'(ob_rdy[0]), 32'd1);
        m_vld[0] = 1'b0;
        step();
        chk("t1_m0_rsp_vld", 32'(ob_rvld[0]), 32'd1);
        chk("t1_m0_rsp_data", ob_rdata[0], 32'hA5A5_0001);
        chk("t1_m1_rsp_vld", 32'(ob_rvld[1]), 32'd0);
        step();
        chk("t1_idle_rsp_rdy", 32'(ob_srrdy), 32'd0);

        // ---- Continuous contention: strict alternation, no bubble ----
        do_reset();
        m_vld[0] = 1'b1; m_addr[0] = 32'h100;
        m_vld[1] = 1'b1; m_addr[1] = 32'h200;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_s_req_vld", 32'(ob_svld), 32'd1);
            chk("t2_s_req_addr", ob_saddr, (i % 2 == 0) ? 32'h100 : 32'h200);
        end
        m_vld[0] = 1'b0; m_vld[1] = 1'b0;
        step();
        step();

        // ---- m1 alone, four back-to-back requests ----
        do_reset();
        m_vld[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_addr[1] = 32'h40 + 32'(4 * i);
            step();
            chk("t3_m1_req_rdy", 32'(ob_rdy[1]), 32'd1);
            chk("t3_s_req_addr", ob_saddr, 32'h40 + 32'(4 * i));
        end
        m_vld[1] = 1'b0;
        step();
        chk("t3_m1_rsp_vld", 32'(ob_rvld[1]), 32'd1);
        chk("t3_m1_rsp_data", ob_rdata[1], 32'hA5A5_0004);

        // ---- Slave back-pressure locks the grant ----
        do_reset();
        s_rdy = 1'b0;
        m_vld[0] = 1'b1; m_addr[0] = 32'h300;
        step();
        chk("t4_s_req_addr0", ob_saddr, 32'h300);
        m_vld[1] = 1'b1; m_addr[1] = 32'h400;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t4_s_req_addr", ob_saddr, 32'h300);
            chk("t4_m1_req_rdy", 32'(ob_rdy[1]), 32'd0);
        end
        s_rdy = 1'b1;
        step();
        chk("t4_m0_accept", 32'(ob_rdy[0]), 32'd1);
        m_vld[0] = 1'b0;
        step();
        chk("t4_m1_accept", 32'(ob_rdy[1]), 32'd1);
        m_vld[1] = 1'b0;
        step();

        // ---- Owner stalls its response; m1 waits, then same-cycle issue ----
        do_reset();
        m_vld[0] = 1'b1; m_addr[0] = 32'h500;
        step();
        m_vld[0] = 1'b0;
        m_vld[1] = 1'b1; m_addr[1] = 32'h600;
        m_rrdy[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t5_s_rsp_rdy", 32'(ob_srrdy), 32'd0);
            chk("t5_m1_req_rdy", 32'(ob_rdy[1]), 32'd0);
            chk("t5_s_req_vld", 32'(ob_svld), 32'd0);
        end
        m_rrdy[0] = 1'b1;
        step();
        chk("t5_m1_accept", 32'(ob_rdy[1]), 32'd1);
        chk("t5_s_rsp_rdy_hs", 32'(ob_srrdy), 32'd1);
        m_vld[1] = 1'b0;
        step();

        // ---- Reset while BUSY with owner=1 ----
        do_reset();
        s_dly_cfg = 5;
        m_vld[1] = 1'b1; m_addr[1] = 32'h700;
        step();
        m_vld[1] = 1'b0;
        step();
        s_dly_cfg = 0;
        do_reset();
        s_stray = 1'b1;
        step();
        chk("t6_s_req_vld", 32'(ob_svld), 32'd0);
        chk("t6_m0_rsp_vld", 32'(ob_rvld[0]), 32'd0);
        chk("t6_m1_rsp_vld", 32'(ob_rvld[1]), 32'd0);
        chk("t6_s_rsp_rdy", 32'(ob_srrdy), 32'd0);
        s_stray = 1'b0;
        m_vld[0] = 1'b1; m_addr[0] = 32'h800;
        m_vld[1] = 1'b1; m_addr[1] = 32'h900;
        step();
        chk("t6_first_gnt_m0", 32'(ob_rdy[0]), 32'd1);
        chk("t6_first_gnt_m1", 32'(ob_rdy[1]), 32'd0);
        m_vld[0] = 1'b0; m_vld[1] = 1'b0;
        step();
        step();

        // ---- Randomized traffic against the reference ----
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            for (int x = 0; x < 2; x++) begin
                // A master keeps its request until it is accepted.
                if (!m_vld[x] || (e_acc && e_g == x)) begin
                    m_vld[x]  = ($urandom_range(0, 99) < 55);
                    m_addr[x] = $urandom & 32'h0000_FFFC;
                end
                m_rrdy[x] = ($urandom_range(0, 99) < 75);
            end
            s_rdy     = ($urandom_range(0, 99) < 70);
            s_dly_cfg = $urandom_range(0, 2);
            s_stray   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
